// File: rtl/pnc_stmc_packet_sequencer_pkg.sv
// pnc_stmc_packet_sequencer_pkg: op encodings, header bit positions, FSM states and header decode
package pnc_stmc_packet_sequencer_pkg;
  typedef logic [1:0] op_ctrl_t;
  localparam op_ctrl_t OP_NONE  = 2'b00;
  localparam op_ctrl_t OP_RC    = 2'b01;
  localparam op_ctrl_t OP_LC    = 2'b10;
  localparam op_ctrl_t OP_PARAM = 2'b11;
  localparam int HDR_PARAM_BIT = 15;
  localparam int HDR_RC_BIT    = 14;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_PDATA = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;
  function automatic op_ctrl_t hdr_ctrl(input logic [15:0] h);
    return h[HDR_PARAM_BIT] ? OP_PARAM : h[HDR_RC_BIT] ? OP_RC : OP_LC;
  endfunction
  function automatic logic [13:0] hdr_addr(input logic [15:0] h);
    return h[HDR_PARAM_BIT] ? {7'b0, h[14:8]} : h[13:0];
  endfunction
endpackage

// File: rtl/pnc_stmc_packet_sequencer_if.sv
// pnc_stmc_packet_sequencer_if: ingress flit and STMC op handshake bundle
interface pnc_stmc_packet_sequencer_if;
  import pnc_stmc_packet_sequencer_pkg::*;
  logic        in_valid;
  logic [15:0] in_flit;
  logic        in_ready;
  logic        op_valid;
  op_ctrl_t    op_ctrl;
  logic [13:0] op_addr;
  logic [15:0] op_data;
  logic        op_ack;
  modport master (
    output in_valid, in_flit, op_ack,
    input  in_ready, op_valid, op_ctrl, op_addr, op_data
  );
  modport slave (
    input  in_valid, in_flit, op_ack,
    output in_ready, op_valid, op_ctrl, op_addr, op_data
  );
endinterface

// File: rtl/pnc_sync_fifo.sv
// pnc_sync_fifo: synchronous FIFO with extra-MSB pointers for full/empty detection
module pnc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign full_o  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
  assign empty_o = wp_q == rp_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rp_q[AW-1:0]];
  // pointer update; a push while full is refused even if a pop happens alongside
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(do_push);
      rp_q <= rp_q + (AW+1)'(do_pop);
    end
  // storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/pnc_stmc_packet_sequencer.sv
// pnc_stmc_packet_sequencer: buffers ingress flits, decodes packets into STMC ops, counts spikes
module pnc_stmc_packet_sequencer
  import pnc_stmc_packet_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pnc_stmc_packet_sequencer_if.slave  bus,
  output logic                        busy,
  output logic [CNT_W-1:0]            rc_cnt,
  output logic [CNT_W-1:0]            lc_cnt
);
  logic [1:0] state_q, state_d;
  op_ctrl_t ctrl_q, ctrl_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] data_q, data_d, head;
  logic [CNT_W-1:0] rc_q, rc_d, lc_q, lc_d;
  logic full, empty, pop, ack;
  pnc_sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .data_i  (bus.in_flit),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign pop          = state_q == ST_HDR || (state_q == ST_PDATA && !empty);
  assign ack          = state_q == ST_ISSUE && bus.op_ack;
  assign bus.in_ready = !full;
  assign bus.op_valid = state_q == ST_ISSUE;
  assign bus.op_ctrl  = ctrl_q;
  assign bus.op_addr  = addr_q;
  assign bus.op_data  = data_q;
  assign busy         = state_q != ST_IDLE || !empty;
  assign rc_cnt       = rc_q;
  assign lc_cnt       = lc_q;
  // header decode, param data capture, op retire and saturating spike counts
  always_comb begin
    state_d = state_q == ST_IDLE  ? (empty ? ST_IDLE : ST_HDR) :
              state_q == ST_HDR   ? (head[HDR_PARAM_BIT] ? ST_PDATA : ST_ISSUE) :
              state_q == ST_PDATA ? (empty ? ST_PDATA : ST_ISSUE) :
                                    (bus.op_ack ? ST_IDLE : ST_ISSUE);
    ctrl_d  = state_q == ST_HDR ? hdr_ctrl(head) : ack ? OP_NONE : ctrl_q;
    addr_d  = state_q == ST_HDR ? hdr_addr(head) : addr_q;
    data_d  = state_q == ST_HDR ? '0 : (state_q == ST_PDATA && !empty) ? head : data_q;
    rc_d    = (ack && ctrl_q == OP_RC && rc_q != '1) ? rc_q + CNT_W'(1) : rc_q;
    lc_d    = (ack && ctrl_q == OP_LC && lc_q != '1) ? lc_q + CNT_W'(1) : lc_q;
  end
  // state registers; reset drops any pending op without counting it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= OP_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      rc_q    <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rc_q    <= rc_d;
      lc_q    <= lc_d;
    end
endmodule

// File: tb/tb_pnc_stmc_packet_sequencer.sv
// tb_pnc_stmc_packet_sequencer: randomized scoreboard bench with a packet-level reference model
module tb_pnc_stmc_packet_sequencer;
  import pnc_stmc_packet_sequencer_pkg::*;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  typedef struct { op_ctrl_t c; logic [13:0] a; logic [15:0] d; } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic [CNT_W-1:0] rc_cnt, lc_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int rc_m = 0;
  int lc_m = 0;
  int ack_mode = 0;
  op_t exp_q[$];
  logic pend = 1'b0;
  logic [13:0] pend_addr = '0;

  pnc_stmc_packet_sequencer_if bus();
  pnc_stmc_packet_sequencer #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .rc_cnt (rc_cnt),
    .lc_cnt (lc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // packet-level reference: each accepted flit either completes a packet or opens a param packet
  task automatic model_push(input logic [15:0] f);
    if (pend) begin
      exp_q.push_back('{OP_PARAM, pend_addr, f});
      pend = 1'b0;
    end else if (f[15]) begin
      pend = 1'b1;
      pend_addr = {7'b0, f[14:8]};
    end else
      exp_q.push_back('{f[14] ? OP_RC : OP_LC, f[13:0], 16'h0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_flit = f;
    while (!bus.in_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("push_timeout", 32'(bus.in_ready), 32'd1);
    else begin
      model_push(f);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    pend = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.op_valid && n < 50);
  endtask

  always @(posedge clk) begin
    #1;
    bus.op_ack = ack_mode == 1 ? 1'b1 : ack_mode == 2 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // monitor: reset values while in reset, otherwise counters every cycle and ops on accept
  always @(negedge clk) begin
    op_t e;
    if (!rst_n) begin
      exp_q.delete();
      rc_m = 0;
      lc_m = 0;
      chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_ctrl", 32'(bus.op_ctrl), 32'd0);
      chk("rst_op_addr", 32'(bus.op_addr), 32'd0);
      chk("rst_op_data", 32'(bus.op_data), 32'd0);
      chk("rst_rc_cnt", 32'(rc_cnt), 32'd0);
      chk("rst_lc_cnt", 32'(lc_cnt), 32'd0);
    end else begin
      chk("rc_cnt", 32'(rc_cnt), 32'(rc_m));
      chk("lc_cnt", 32'(lc_cnt), 32'(lc_m));
      if (bus.op_valid) chk("busy_when_valid", 32'(busy), 32'd1);
      if (bus.op_valid && bus.op_ack) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_op: got ctrl %0d addr 0x%0h data 0x%0h, required no op",
                   bus.op_ctrl, bus.op_addr, bus.op_data);
        end else begin
          e = exp_q.pop_front();
          chk("op_ctrl", 32'(bus.op_ctrl), 32'(e.c));
          chk("op_addr", 32'(bus.op_addr), 32'(e.a));
          chk("op_data", 32'(bus.op_data), 32'(e.d));
          if (e.c == OP_RC && rc_m < MAXC) rc_m++;
          if (e.c == OP_LC && lc_m < MAXC) lc_m++;
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [15:0] bp [5];
    bp = '{16'h4011, 16'h0022, 16'h4033, 16'h0044, 16'h3FFF};
    bus.in_valid = 1'b0;
    bus.in_flit = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_mode = 1;
    repeat (2) tick();
    send(16'h4005);
    wait_valid(n);
    chk("spike_latency", 32'(n), 32'd3);
    @(posedge clk);
    #1;
    drain();
    chk("rc_after_spike", 32'(rc_cnt), 32'd1);
    send(16'h0123);
    drain();
    chk("lc_after_spike", 32'(lc_cnt), 32'd1);
    send(16'h8A00);
    repeat (4) begin
      @(negedge clk);
      chk("pdata_hold_valid", 32'(bus.op_valid), 32'd0);
    end
    chk("pdata_hold_busy", 32'(busy), 32'd1);
    tick();
    send(16'hBEEF);
    drain();
    chk("param_no_count", 32'({rc_cnt, lc_cnt}), 32'({2'd1, 2'd1}));
    do_reset();
    ack_mode = 1;
    repeat (5) send({2'b01, 14'($urandom)});
    drain();
    chk("rc_saturated", 32'(rc_cnt), 32'(MAXC));
    chk("lc_untouched", 32'(lc_cnt), 32'd0);
    do_reset();
    ack_mode = 0;
    for (int i = 0; i < 5; i++) send(bp[i]);
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    tick();
    ack_mode = 2;
    send(16'h7ABC);
    drain();
    ack_mode = 0;
    send(16'h4055);
    wait_valid(n);
    chk("held_op_valid", 32'(bus.op_valid), 32'd1);
    tick();
    do_reset();
    ack_mode = 1;
    repeat (5) tick();
    chk("after_rst_valid", 32'(bus.op_valid), 32'd0);
    chk("after_rst_rc", 32'(rc_cnt), 32'd0);
    ack_mode = 2;
    for (int p = 0; p < 160; p++) begin
      if (p % 40 == 39) do_reset();
      r = $urandom_range(0, 3);
      if (r == 0) begin
        send({1'b1, 15'($urandom)});
        repeat ($urandom_range(0, 2)) tick();
        send(16'($urandom));
      end else if (r == 1) send({2'b01, 14'($urandom)});
      else send({2'b00, 14'($urandom)});
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("final_idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
